// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: loads a pattern into a scan chain, runs a functional
// capture window, unloads the captured state and compares it with an expected value.
module scan_test_ctrl #(
    parameter int unsigned CHAIN_LEN      = 8,
    parameter int unsigned CAPTURE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 func_en,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] response,
    output logic [7:0]           fail_cnt
);

    localparam int unsigned MAX_LEN = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;
    localparam int unsigned SHIFT_W = CHAIN_LEN - 1;

    localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SHIFT_W-1:0]   shift_q;
    logic [CHAIN_LEN-1:0] expected_q;
    logic [CNT_W-1:0]     cnt;
    logic                 accept_c;
    logic                 phase_change_c;
    logic                 counting_c;
    logic [CHAIN_LEN-1:0] unload_word_c;

    // scan_in is the MSB of the load shift register; shift_q holds the remaining bits
    always_comb begin
        state_nxt      = state;
        accept_c       = start && ((state == ST_IDLE) || (state == ST_DONE));
        unload_word_c  = {response[CHAIN_LEN-2:0], scan_out};
        counting_c     = (state == ST_LOAD) || (state == ST_CAPTURE) || (state == ST_UNLOAD);

        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt == CHAIN_LAST) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cnt == CAP_LAST) begin
                    state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (cnt == CHAIN_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = accept_c ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        phase_change_c = (state_nxt != state);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift_q    <= '0;
            expected_q <= '0;
            cnt        <= '0;
            scan_en    <= 1'b0;
            scan_in    <= 1'b0;
            func_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            response   <= '0;
            fail_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (phase_change_c) begin
                cnt <= '0;
            end else if (counting_c) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept_c) begin
                scan_in    <= pattern[CHAIN_LEN-1];
                shift_q    <= pattern[SHIFT_W-1:0];
                expected_q <= expected;
            end else if ((state == ST_LOAD) && (state_nxt == ST_LOAD)) begin
                scan_in <= shift_q[SHIFT_W-1];
                shift_q <= {shift_q[SHIFT_W-2:0], 1'b0};
            end else begin
                scan_in <= 1'b0;
            end

            scan_en <= (state_nxt == ST_LOAD) || (state_nxt == ST_UNLOAD);
            func_en <= (state_nxt == ST_CAPTURE);
            busy    <= (state_nxt == ST_LOAD) || (state_nxt == ST_CAPTURE) ||
                       (state_nxt == ST_UNLOAD);
            done    <= (state_nxt == ST_DONE);

            if (state == ST_UNLOAD) begin
                response <= unload_word_c;
            end

            // Verdict taken on the final unload edge, using the fully assembled word
            if ((state == ST_UNLOAD) && (state_nxt == ST_DONE)) begin
                pass <= (unload_word_c == expected_q);
                if ((unload_word_c != expected_q) && (fail_cnt != 8'hFF)) begin
                    fail_cnt <= fail_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl driving a behavioural 8-bit scan counter chain.
module tb_scan_test_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [7:0] expected = '0;
    logic       scan_en;
    logic       scan_in;
    logic       func_en;
    logic       scan_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] response;
    logic [7:0] fail_cnt;

    logic [7:0] chain_q = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] exp;
        logic [7:0] resp;
        logic       pass;
        logic [7:0] fc;
    } vec_t;

    vec_t vecs [5];

    scan_test_ctrl #(
        .CHAIN_LEN      (8),
        .CAPTURE_CYCLES (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .expected (expected),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .func_en  (func_en),
        .scan_out (scan_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .response (response),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    // Scan-capable counter: shifts toward MSB in scan mode, increments when enabled
    always @(posedge clk) begin
        if (scan_en) begin
            chain_q <= {chain_q[6:0], scan_in};
        end else if (func_en) begin
            chain_q <= chain_q + 8'd1;
        end
    end
    assign scan_out = chain_q[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected {scan_en, func_en, done, busy} in cycle m (1..18) of a test
    function automatic logic [3:0] sched(input int m);
        logic se;
        logic fe;
        logic dn;
        logic bs;
        se = ((m >= 1) && (m <= 8)) || ((m >= 10) && (m <= 17));
        fe = (m == 9);
        dn = (m == 18);
        bs = (m >= 1) && (m <= 17);
        return {se, fe, dn, bs};
    endfunction

    // Issue one test from a negedge; optional ignored start pulses in cycles 3 and 12
    task automatic run_test(input logic [7:0] pat, input logic [7:0] exp,
                            input logic [7:0] e_resp, input logic e_pass,
                            input logic [7:0] e_fc, input bit pulse);
        logic [3:0] act_v;
        logic [3:0] exp_v;
        bit         bad;
        bad      = 1'b0;
        act_v    = '0;
        exp_v    = '0;
        pattern  = pat;
        expected = exp;
        start    = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!bad) begin
                act_v = {scan_en, func_en, done, busy};
                exp_v = sched(k);
                if (act_v !== exp_v) begin
                    bad = 1'b1;
                    $display("schedule deviation at cycle %0d", k);
                end
            end
            if (pulse && ((k == 3) || (k == 12))) begin
                start    = 1'b1;
                pattern  = 8'h55;
                expected = 8'h55;
            end
        end
        chk("sched", 32'(act_v), 32'(exp_v));
        chk("response", 32'(response), 32'(e_resp));
        chk("pass", 32'(pass), 32'(e_pass));
        chk("fail_cnt", 32'(fail_cnt), 32'(e_fc));
    endtask

    initial begin
        logic [3:0] act_v;
        logic [3:0] exp_v;
        bit         bad;
        int         e_fc;

        vecs[0] = '{8'hA5, 8'hA6, 8'hA6, 1'b1, 8'd0};
        vecs[1] = '{8'hFF, 8'h00, 8'h00, 1'b1, 8'd0};
        vecs[2] = '{8'h10, 8'h00, 8'h11, 1'b0, 8'd1};
        vecs[3] = '{8'h3C, 8'h3D, 8'h3D, 1'b1, 8'd1};
        vecs[4] = '{8'h80, 8'h00, 8'h81, 1'b0, 8'd2};

        repeat (2) @(negedge clk);
        chk("rst_scan_en", 32'(scan_en), 32'd0);
        chk("rst_func_en", 32'(func_en), 32'd0);
        chk("rst_scan_in", 32'(scan_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_response", 32'(response), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_test(vecs[i].pat, vecs[i].exp, vecs[i].resp, vecs[i].pass, vecs[i].fc, 1'b0);
            @(negedge clk);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Start pulses while busy must be ignored
        run_test(8'h42, 8'h43, 8'h43, 1'b1, 8'd2, 1'b1);
        @(negedge clk);
        chk("pulse_single_done", 32'(done), 32'd0);

        // start held high: back-to-back tests with no double done
        bad      = 1'b0;
        act_v    = '0;
        exp_v    = '0;
        pattern  = 8'h00;
        expected = 8'h01;
        start    = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (!bad) begin
                act_v = {scan_en, func_en, done, busy};
                exp_v = sched(((k - 1) % 18) + 1);
                if (act_v !== exp_v) begin
                    bad = 1'b1;
                    $display("back-to-back schedule deviation at cycle %0d", k);
                end
            end
            if (k == 18) begin
                chk("b2b_resp0", 32'(response), 32'h01);
                chk("b2b_pass0", 32'(pass), 32'd1);
                pattern  = 8'h7F;
                expected = 8'h80;
            end
            if (k == 36) begin
                chk("b2b_resp1", 32'(response), 32'h80);
                chk("b2b_pass1", 32'(pass), 32'd1);
                start = 1'b0;
            end
        end
        chk("b2b_sched", 32'(act_v), 32'(exp_v));
        @(negedge clk);
        chk("b2b_end_done", 32'(done), 32'd0);
        chk("b2b_end_busy", 32'(busy), 32'd0);

        // Drive fail_cnt through saturation
        for (int i = 1; i <= 256; i++) begin
            e_fc = (2 + i > 255) ? 255 : 2 + i;
            run_test(8'h10, 8'h00, 8'h11, 1'b0, 8'(e_fc), 1'b0);
        end
        @(negedge clk);
        chk("sat_fail_cnt", 32'(fail_cnt), 32'd255);

        // Reset in LOAD cycle 4
        pattern  = 8'hC3;
        expected = 8'hC4;
        start    = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_load_scan_en", 32'(scan_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_scan_en", 32'(scan_en), 32'd0);
        chk("mrst_func_en", 32'(func_en), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_response", 32'(response), 32'd0);
        chk("mrst_pass", 32'(pass), 32'd0);
        chk("mrst_fail_cnt", 32'(fail_cnt), 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || scan_en || busy) begin
                bad = 1'b1;
            end
        end
        chk("mrst_quiet", 32'(bad), 32'd0);
        run_test(8'h5A, 8'h5B, 8'h5B, 1'b1, 8'd0, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_test_ctrl.md
# scan_test_ctrl

Scan test sequencer that drives an 8-bit scan-chain counter stage and consumes its scan output. Per accepted request it shifts a test pattern into the chain, runs a functional capture window, shifts the captured state back out, and compares it with an expected value. It sits between the test host (pattern/expected/start) and the scan-capable counter (scan_en/scan_in/enable in, scan_out back).

## Interface

- CHAIN_LEN, 8, scan chain length in flops; also width of pattern/expected/response
- CAPTURE_CYCLES, 1, functional-mode cycles between load and unload (>=1)

- clk  in  1  rising-edge clock, shared with the chain under test
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted on an edge where start=1 and busy=0
- pattern  in  CHAIN_LEN  value to load into the chain; latched on accept
- expected  in  CHAIN_LEN  expected captured state; latched on accept
- scan_en  out  1  chain scan-mode enable
- scan_in  out  1  serial data into chain LSB
- func_en  out  1  drives chain functional enable during capture
- scan_out  in  1  serial data from chain MSB
- busy  out  1  high in LOAD, CAPTURE, UNLOAD
- done  out  1  one-cycle pulse, DONE state
- pass  out  1  response==expected for last test; held until next DONE or reset
- response  out  CHAIN_LEN  last unloaded chain state; held
- fail_cnt  out  8  failed tests since reset, saturates at 255

## Operation

- FSM: IDLE -> LOAD -> CAPTURE -> UNLOAD -> DONE -> IDLE.
- IDLE: scan_en=0, func_en=0, scan_in=0. Accepted start latches pattern into shift register, expected into compare register, clears bit counter, goes to LOAD.
- LOAD (CHAIN_LEN cycles): scan_en=1; scan_in = shift-register MSB; shift register shifts left each edge. Pattern MSB first, so after CHAIN_LEN edges chain holds pattern exactly.
- CAPTURE (CAPTURE_CYCLES cycles): scan_en=0, func_en=1, scan_in=0.
- UNLOAD (CHAIN_LEN cycles): scan_en=1, func_en=0, scan_in=0 (chain flushed to zero). Each edge: response <= {response[CHAIN_LEN-2:0], scan_out}. After CHAIN_LEN edges response equals captured chain state.
- DONE (1 cycle): done=1; pass and response updated at the edge entering DONE; fail_cnt increments at the same edge if mismatch (saturating). busy=0; start here is accepted and goes directly to LOAD (back-to-back).
- scan_en, scan_in, func_en, busy, done decoded from state/data flops only; no combinational path from any input.
- Bit counter width $clog2(max(CHAIN_LEN,CAPTURE_CYCLES))+1; counts 0..N-1 per phase, cleared on each phase entry.
- start while busy=1: ignored, no latching, no effect.
- Reset values: state=IDLE, scan_en=0, scan_in=0, func_en=0, busy=0, done=0, pass=0, response=0, fail_cnt=0.
- rst during any state: next edge returns IDLE with all reset values; the chain's contents are undefined and not restored.

## Timing

- Accept edge = E0. LOAD occupies cycles after E0..E(N); CAPTURE next C cycles; UNLOAD next N cycles; DONE cycle follows.
- Defaults: scan_en=1 cycles 1-8, func_en=1 cycle 9, scan_en=1 cycles 10-17, done=1 cycle 18.
- Latency start-accept to done = 2*CHAIN_LEN + CAPTURE_CYCLES + 1 cycles (18 default).
- Back-to-back: start held high gives one test every 2N+C+1 cycles; done never pulses two consecutive cycles.
- For the counter chain with enable=func_en, C=1: captured = pattern+1 mod 2^N.

## Test plan

- Reset, then pattern=8'hA5, expected=8'hA6, start 1 cycle -> scan_en high cycles 1-8 and 10-17, func_en cycle 9, done cycle 18, pass=1, response=8'hA6, fail_cnt=0.
- pattern=8'hFF, expected=8'h00 -> wrap-around; response=8'h00, pass=1.
- pattern=8'h10, expected=8'h00 -> response=8'h11, pass=0, fail_cnt=1; repeat 256 more fails -> fail_cnt stays 255.
- start pulsed at cycles 3 and 12 of a running test -> ignored; single done at cycle 18, response from first pattern.
- rst asserted during LOAD cycle 4 -> next cycle scan_en=0, busy=0, response=0, pass=0, no done; new start afterward completes normally.
- start held high across two tests with patterns 8'h00 then 8'h7F -> done at cycles 18 and 36, responses 8'h01 then 8'h80, pass=1 both.
